ternary_scoreboard_dual: RTL and testbench
==========================================

// Module: ternary_scoreboard_dual
// PURPOSE
//  Dual-issue register scoreboard. It is the producer-side counterpart of the dual forwarding unit.
//  It records in-flight destination writes at issue time and grants or withholds issue for slot A and slot B.
//  A consumer issues only when its operand will be reachable through the EX_A/MEM/WB forward paths, or is already architectural.
//  Sits in ID, between the dual decoder and the ID/EX pipeline register.
// PARAMETERS
//  CNT_W      3   width of per-register countdown; LAT_LONG = 2**CNT_W-1 (all ones)
//  PERF_W     16  width of saturating stall-cycle counter
// PORTS
//  clk              in   1        clock
//  rst              in   1        synchronous reset, active-high
//  flush            in   1        pipeline flush: blocks issue this cycle, no state change
//  issue_valid_a    in   1        slot A holds a decoded instruction
//  rs1_a, rs2_a     in   trit_t[2:0]  slot A source addresses
//  use_rs1_a, use_rs2_a in 1      slot A actually reads rs1/rs2
//  rd_a             in   trit_t[2:0]  slot A destination
//  reg_write_a      in   1        slot A writes rd_a
//  lat_a            in   CNT_W    slot A result latency: 1=ALU, 2=load, LAT_LONG=variable (mul/div)
//  issue_valid_b, rs1_b, rs2_b, use_rs1_b, use_rs2_b, rd_b, reg_write_b, lat_b   same, slot B
//  complete_valid   in   1        variable-latency unit result enters MEM this cycle
//  complete_rd      in   trit_t[2:0]  destination of that completing result
//  issue_ready_a    out  1        slot A may issue (combinational)
//  issue_ready_b    out  1        slot B may issue (combinational)
//  busy_vec         out  27       bit i set when reg index i has cnt != 0 (registered)
//  stall_cycles     out  PERF_W   cycles with issue_valid_a && !issue_ready_a (saturating)
// BEHAVIOUR
//  Indexing
//  - idx = 9*t2 + 3*t1 + t0 + 13, range 0..26. R0 maps to idx 13.
//  - R0 is never busy. Writes to R0 are ignored. Reads of R0 never stall.
//  State
//  - cnt[0:26], CNT_W bits each. cnt = cycles remaining before a consumer may issue.
//  - On rst: all cnt=0, stall_cycles=0, busy_vec=0.
//  - Outputs are zero during rst.
//  Fire conditions
//  - fire_a = issue_valid_a && issue_ready_a.
//  - fire_b = issue_valid_b && issue_ready_b.
//  - Issue is in order: issue_ready_b requires fire_a.
//  issue_ready_a is high iff all of:
//  - !flush.
//  - No used source with cnt != 0.
//  - When reg_write_a: cnt[rd_a] == 0 (WAW guard).
//  issue_ready_b is high iff all of:
//  - issue_ready_a && issue_valid_a.
//  - No used source with cnt != 0.
//  - When reg_write_b: cnt[rd_b] == 0.
//  - If A writes rd_a != R0 and a used B source == rd_a: lat_a must be 1 (EX_A forward). Any other lat_a blocks B.
//  - If both slots write the same non-R0 rd: B is blocked.
//  Update at posedge (evaluated in priority order, highest first)
//  1. rst.
//  2. Issue set: on fire_x && reg_write_x && rd != R0, cnt[rd] <= (lat_x==LAT_LONG) ? LAT_LONG : max(lat_x,1)-1.
//  3. Completion: complete_valid clears cnt[complete_rd] to 0, only if it is LAT_LONG. Issue set on the same register wins.
//  4. Decrement: every other cnt with 0 < cnt < LAT_LONG decrements by 1. This happens regardless of stalls.
//  - lat_x = 0 is treated as 1.
//  - complete_valid on a register not at LAT_LONG is a no-op.
//  - flush does not clear counters; already-issued producers still retire.
//  - stall_cycles increments when issue_valid_a && !issue_ready_a && !flush, and saturates at all ones.
//  Latency
//  - An ALU producer (lat 1) never stalls a consumer.
//  - A load (lat 2) stalls a dependent instruction issued the next cycle by exactly 1 cycle.
// TESTING
//  1. rst, then A: ADD r(+,0,0) lat1; next cycle A reads it -> ready_a=1 every cycle, busy_vec=0.
//  2. A: LD rd=idx 5 lat2; next cycle A uses idx5 -> ready_a=0 for 1 cycle, then 1; stall_cycles=1.
//  3. Pair A writes idx7 lat1, B reads idx7 -> ready_b=1. Same pair with lat_a=2 -> ready_a=1, ready_b=0.
//  4. A DIV rd=idx20 LAT_LONG; consumer waits 10 cycles -> ready_a=0 throughout. complete_valid idx20 -> ready_a=1 next cycle.
//  5. complete_valid idx20 and fire_a writing idx20 lat2 in the same cycle -> cnt[20]=1 and busy_vec[20]=1 afterwards.
//  6. Writes to R0 (idx13) with any lat -> busy_vec[13] stays 0. rst asserted mid-DIV -> all busy cleared, ready_a=1.

Source files
------------

// File: rtl/ternary_scoreboard_dual.sv
// Dual-issue scoreboard for a balanced-ternary register file: tracks in-flight
// destination writes and decides per cycle whether slot A and slot B may issue.

package ternary_scoreboard_dual_pkg;
  // Trit encoding: 2'b01 = +1, 2'b11 = -1, anything else = 0
  typedef logic [1:0] trit_t;

  localparam int unsigned NUM_REGS = 27;
  localparam int unsigned IDX_W    = 5;
  localparam logic [IDX_W-1:0] R0_IDX = 5'd13;

  function automatic int trit_val(input trit_t t);
    case (t)
      2'b01:   return 1;
      2'b11:   return -1;
      default: return 0;
    endcase
  endfunction

  // Register address (t2,t1,t0) -> flat index 0..26, R0 lands on 13
  function automatic logic [IDX_W-1:0] reg_idx(input trit_t [2:0] a);
    int v;
    v = 9 * trit_val(a[2]) + 3 * trit_val(a[1]) + trit_val(a[0]) + 13;
    return IDX_W'(v);
  endfunction
endpackage

module ternary_scoreboard_dual
  import ternary_scoreboard_dual_pkg::*;
#(
  parameter int unsigned CNT_W  = 3,
  parameter int unsigned PERF_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                issue_valid_a,
  input  trit_t [2:0]         rs1_a,
  input  trit_t [2:0]         rs2_a,
  input  logic                use_rs1_a,
  input  logic                use_rs2_a,
  input  trit_t [2:0]         rd_a,
  input  logic                reg_write_a,
  input  logic [CNT_W-1:0]    lat_a,
  input  logic                issue_valid_b,
  input  trit_t [2:0]         rs1_b,
  input  trit_t [2:0]         rs2_b,
  input  logic                use_rs1_b,
  input  logic                use_rs2_b,
  input  trit_t [2:0]         rd_b,
  input  logic                reg_write_b,
  input  logic [CNT_W-1:0]    lat_b,
  input  logic                complete_valid,
  input  trit_t [2:0]         complete_rd,
  output logic                issue_ready_a,
  output logic                issue_ready_b,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [PERF_W-1:0]   stall_cycles
);

  localparam logic [CNT_W-1:0] LAT_LONG = '1;

  logic [CNT_W-1:0] cnt     [NUM_REGS];
  logic [CNT_W-1:0] cnt_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] busy_nxt;

  logic [IDX_W-1:0] rs1_a_idx, rs2_a_idx, rd_a_idx;
  logic [IDX_W-1:0] rs1_b_idx, rs2_b_idx, rd_b_idx;
  logic [IDX_W-1:0] cmp_idx;

  logic src_ok_a, waw_ok_a, src_ok_b, waw_ok_b;
  logic a_writes, raw_ab, lat_a_alu, same_rd;
  logic fire_a, fire_b;
  logic set_a, set_b;
  logic [CNT_W-1:0] set_val_a, set_val_b;

  // Countdown loaded at issue: long ops park at LAT_LONG until completion
  function automatic logic [CNT_W-1:0] set_val(input logic [CNT_W-1:0] lat);
    if (lat == LAT_LONG)
      return LAT_LONG;
    else if (lat <= CNT_W'(1))
      return '0;
    else
      return lat - CNT_W'(1);
  endfunction

  assign rs1_a_idx = reg_idx(rs1_a);
  assign rs2_a_idx = reg_idx(rs2_a);
  assign rd_a_idx  = reg_idx(rd_a);
  assign rs1_b_idx = reg_idx(rs1_b);
  assign rs2_b_idx = reg_idx(rs2_b);
  assign rd_b_idx  = reg_idx(rd_b);
  assign cmp_idx   = reg_idx(complete_rd);

  // Issue readiness for both slots; B also checks the intra-pair hazard with A
  always_comb begin
    src_ok_a = (!use_rs1_a || (cnt[rs1_a_idx] == '0)) &&
               (!use_rs2_a || (cnt[rs2_a_idx] == '0));
    waw_ok_a = !reg_write_a || (cnt[rd_a_idx] == '0);
    issue_ready_a = !rst && !flush && src_ok_a && waw_ok_a;

    src_ok_b = (!use_rs1_b || (cnt[rs1_b_idx] == '0)) &&
               (!use_rs2_b || (cnt[rs2_b_idx] == '0));
    waw_ok_b = !reg_write_b || (cnt[rd_b_idx] == '0);

    a_writes  = reg_write_a && (rd_a_idx != R0_IDX);
    raw_ab    = a_writes && ((use_rs1_b && (rs1_b_idx == rd_a_idx)) ||
                             (use_rs2_b && (rs2_b_idx == rd_a_idx)));
    lat_a_alu = (lat_a <= CNT_W'(1));
    same_rd   = a_writes && reg_write_b && (rd_b_idx == rd_a_idx);

    issue_ready_b = issue_ready_a && issue_valid_a && src_ok_b && waw_ok_b &&
                    !(raw_ab && !lat_a_alu) && !same_rd;
  end

  assign fire_a = issue_valid_a && issue_ready_a;
  assign fire_b = issue_valid_b && issue_ready_b;

  assign set_a     = fire_a && reg_write_a && (rd_a_idx != R0_IDX);
  assign set_b     = fire_b && reg_write_b && (rd_b_idx != R0_IDX);
  assign set_val_a = set_val(lat_a);
  assign set_val_b = set_val(lat_b);

  // Per-register next count: issue set > completion clear > decrement
  always_comb begin
    busy_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (set_a && (rd_a_idx == IDX_W'(i)))
        cnt_nxt[i] = set_val_a;
      else if (set_b && (rd_b_idx == IDX_W'(i)))
        cnt_nxt[i] = set_val_b;
      else if (complete_valid && (cmp_idx == IDX_W'(i)) && (cnt[i] == LAT_LONG))
        cnt_nxt[i] = '0;
      else if ((cnt[i] != '0) && (cnt[i] != LAT_LONG))
        cnt_nxt[i] = cnt[i] - CNT_W'(1);
      busy_nxt[i] = (cnt_nxt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        cnt[i] <= '0;
      busy_vec     <= '0;
      stall_cycles <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        cnt[i] <= cnt_nxt[i];
      busy_vec <= busy_nxt;
      // Flush cycles are not charged as stalls
      if (issue_valid_a && !issue_ready_a && !flush && (stall_cycles != '1))
        stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_ternary_scoreboard_dual.sv
// Directed bench for ternary_scoreboard_dual: forwarding-aware issue, load and
// long-latency stalls, completion, R0 handling and reset.

module tb_ternary_scoreboard_dual;
  import ternary_scoreboard_dual_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        issue_valid_a, use_rs1_a, use_rs2_a, reg_write_a;
  trit_t [2:0] rs1_a, rs2_a, rd_a;
  logic [2:0]  lat_a;
  logic        issue_valid_b, use_rs1_b, use_rs2_b, reg_write_b;
  trit_t [2:0] rs1_b, rs2_b, rd_b;
  logic [2:0]  lat_b;
  logic        complete_valid;
  trit_t [2:0] complete_rd;
  logic        issue_ready_a, issue_ready_b;
  logic [26:0] busy_vec;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  ternary_scoreboard_dual #(.CNT_W(3), .PERF_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid_a(issue_valid_a), .rs1_a(rs1_a), .rs2_a(rs2_a),
    .use_rs1_a(use_rs1_a), .use_rs2_a(use_rs2_a), .rd_a(rd_a),
    .reg_write_a(reg_write_a), .lat_a(lat_a),
    .issue_valid_b(issue_valid_b), .rs1_b(rs1_b), .rs2_b(rs2_b),
    .use_rs1_b(use_rs1_b), .use_rs2_b(use_rs2_b), .rd_b(rd_b),
    .reg_write_b(reg_write_b), .lat_b(lat_b),
    .complete_valid(complete_valid), .complete_rd(complete_rd),
    .issue_ready_a(issue_ready_a), .issue_ready_b(issue_ready_b),
    .busy_vec(busy_vec), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Flat index 0..26 -> three trits (base-3 digit d encodes trit d-1)
  function automatic trit_t [2:0] mk(input int n);
    trit_t [2:0] r;
    int d;
    for (int k = 0; k < 3; k++) begin
      d = n % 3;
      n = n / 3;
      case (d)
        0:       r[k] = 2'b11;
        1:       r[k] = 2'b00;
        default: r[k] = 2'b01;
      endcase
    end
    return r;
  endfunction

  task automatic idle();
    flush = 0; complete_valid = 0; complete_rd = mk(13);
    issue_valid_a = 0; rs1_a = mk(13); rs2_a = mk(13); use_rs1_a = 0; use_rs2_a = 0;
    rd_a = mk(13); reg_write_a = 0; lat_a = 3'd1;
    issue_valid_b = 0; rs1_b = mk(13); rs2_b = mk(13); use_rs1_b = 0; use_rs2_b = 0;
    rd_b = mk(13); reg_write_b = 0; lat_b = 3'd1;
  endtask

  task automatic drive_a(input int rd, input int lat, input logic wr, input int s1, input logic u1);
    issue_valid_a = 1; rd_a = mk(rd); lat_a = 3'(lat); reg_write_a = wr;
    rs1_a = mk(s1); use_rs1_a = u1; rs2_a = mk(13); use_rs2_a = 0;
  endtask

  task automatic drive_b(input int rd, input int lat, input logic wr, input int s1, input logic u1);
    issue_valid_b = 1; rd_b = mk(rd); lat_b = 3'(lat); reg_write_b = wr;
    rs1_b = mk(s1); use_rs1_b = u1; rs2_b = mk(13); use_rs2_b = 0;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    drive_a(5, 1, 1, 13, 0);
    tick(); #1;
    n_checks++;
    if (issue_ready_a !== 1'b0) begin n_fail++; $display("FAIL rst_ready_a: got %b want 0", issue_ready_a); end
    n_checks++;
    if (busy_vec !== 27'd0) begin n_fail++; $display("FAIL rst_busy: got %h want 0", busy_vec); end
    n_checks++;
    if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL rst_stall: got %0d want 0", stall_cycles); end
    tick();
    rst = 0; idle();
  endtask

  task automatic test_alu();
    drive_a(22, 1, 1, 13, 0); #1;
    n_checks++;
    if (issue_ready_a !== 1'b1) begin n_fail++; $display("FAIL alu_prod_ready: got %b want 1", issue_ready_a); end
    tick();
    drive_a(13, 1, 0, 22, 1); #1;
    n_checks++;
    if (issue_ready_a !== 1'b1) begin n_fail++; $display("FAIL alu_cons_ready: got %b want 1", issue_ready_a); end
    n_checks++;
    if (busy_vec !== 27'd0) begin n_fail++; $display("FAIL alu_busy: got %h want 0", busy_vec); end
    tick(); idle();
  endtask

  task automatic test_load();
    drive_a(5, 2, 1, 13, 0); #1;
    n_checks++;
    if (issue_ready_a !== 1'b1) begin n_fail++; $display("FAIL ld_prod_ready: got %b want 1", issue_ready_a); end
    tick();
    n_checks++;
    if (busy_vec !== 27'h0000020) begin n_fail++; $display("FAIL ld_busy: got %h want 0000020", busy_vec); end
    drive_a(13, 1, 0, 5, 1); #1;
    n_checks++;
    if (issue_ready_a !== 1'b0) begin n_fail++; $display("FAIL ld_stall_ready: got %b want 0", issue_ready_a); end
    tick(); #1;
    n_checks++;
    if (issue_ready_a !== 1'b1) begin n_fail++; $display("FAIL ld_after_ready: got %b want 1", issue_ready_a); end
    n_checks++;
    if (stall_cycles !== 16'd1) begin n_fail++; $display("FAIL ld_stall_cnt: got %0d want 1", stall_cycles); end
    tick(); idle();
  endtask

  task automatic test_dual();
    // ALU result forwarded from EX_A to B in the same pair
    drive_a(7, 1, 1, 13, 0); drive_b(13, 1, 0, 7, 1); #1;
    n_checks++;
    if (issue_ready_b !== 1'b1) begin n_fail++; $display("FAIL dual_lat1_b: got %b want 1", issue_ready_b); end
    tick();
    // lat 0 behaves as ALU
    drive_a(7, 0, 1, 13, 0); drive_b(13, 1, 0, 7, 1); #1;
    n_checks++;
    if (issue_ready_b !== 1'b1) begin n_fail++; $display("FAIL dual_lat0_b: got %b want 1", issue_ready_b); end
    tick();
    drive_a(7, 2, 1, 13, 0); drive_b(13, 1, 0, 7, 1); #1;
    n_checks++;
    if (issue_ready_a !== 1'b1) begin n_fail++; $display("FAIL dual_lat2_a: got %b want 1", issue_ready_a); end
    n_checks++;
    if (issue_ready_b !== 1'b0) begin n_fail++; $display("FAIL dual_lat2_b: got %b want 0", issue_ready_b); end
    tick(); idle();
    n_checks++;
    if (busy_vec !== 27'h0000080) begin n_fail++; $display("FAIL dual_busy7: got %h want 0000080", busy_vec); end
    tick();
    // Same destination in both slots blocks B
    drive_a(8, 1, 1, 13, 0); drive_b(8, 1, 1, 13, 0); #1;
    n_checks++;
    if (issue_ready_b !== 1'b0) begin n_fail++; $display("FAIL dual_waw_b: got %b want 0", issue_ready_b); end
    tick(); idle();
    // B cannot issue without A
    drive_b(13, 1, 0, 13, 0); #1;
    n_checks++;
    if (issue_ready_b !== 1'b0) begin n_fail++; $display("FAIL dual_no_a: got %b want 0", issue_ready_b); end
    tick(); idle();
    // Flush blocks issue and is not counted as a stall
    drive_a(13, 1, 0, 13, 0); flush = 1; #1;
    n_checks++;
    if (issue_ready_a !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", issue_ready_a); end
    tick(); idle();
    n_checks++;
    if (stall_cycles !== 16'd1) begin n_fail++; $display("FAIL flush_stall: got %0d want 1", stall_cycles); end
  endtask

  task automatic test_div();
    int bad;
    drive_a(20, 7, 1, 13, 0); #1;
    n_checks++;
    if (issue_ready_a !== 1'b1) begin n_fail++; $display("FAIL div_prod_ready: got %b want 1", issue_ready_a); end
    tick();
    drive_a(13, 1, 0, 20, 1);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (issue_ready_a !== 1'b0) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL div_wait: got %0d ready cycles want 0", bad); end
    n_checks++;
    if (busy_vec !== 27'h0100000) begin n_fail++; $display("FAIL div_busy: got %h want 0100000", busy_vec); end
    complete_valid = 1; complete_rd = mk(20); #1;
    n_checks++;
    if (issue_ready_a !== 1'b0) begin n_fail++; $display("FAIL div_cmp_cycle: got %b want 0", issue_ready_a); end
    tick();
    complete_valid = 0; #1;
    n_checks++;
    if (issue_ready_a !== 1'b1) begin n_fail++; $display("FAIL div_after_cmp: got %b want 1", issue_ready_a); end
    n_checks++;
    if (stall_cycles !== 16'd12) begin n_fail++; $display("FAIL div_stall_cnt: got %0d want 12", stall_cycles); end
    tick(); idle();
  endtask

  task automatic test_complete_same();
    complete_valid = 1; complete_rd = mk(20);
    drive_a(20, 2, 1, 13, 0); #1;
    n_checks++;
    if (issue_ready_a !== 1'b1) begin n_fail++; $display("FAIL cs_ready: got %b want 1", issue_ready_a); end
    tick(); idle();
    n_checks++;
    if (busy_vec !== 27'h0100000) begin n_fail++; $display("FAIL cs_busy20: got %h want 0100000", busy_vec); end
    tick();
    n_checks++;
    if (busy_vec !== 27'd0) begin n_fail++; $display("FAIL cs_drain: got %h want 0", busy_vec); end
    // Completion on a short-latency counter is ignored
    drive_a(21, 3, 1, 13, 0);
    tick(); idle();
    complete_valid = 1; complete_rd = mk(21);
    tick(); idle();
    n_checks++;
    if (busy_vec !== 27'h0200000) begin n_fail++; $display("FAIL cmp_noop: got %h want 0200000", busy_vec); end
    tick();
  endtask

  task automatic test_r0_and_reset();
    drive_a(13, 7, 1, 13, 1); drive_b(13, 2, 1, 13, 1); #1;
    n_checks++;
    if (issue_ready_b !== 1'b1) begin n_fail++; $display("FAIL r0_ready_b: got %b want 1", issue_ready_b); end
    tick(); idle();
    n_checks++;
    if (busy_vec[13] !== 1'b0 || busy_vec !== 27'd0) begin n_fail++; $display("FAIL r0_busy: got %h want 0", busy_vec); end
    drive_a(20, 7, 1, 13, 0);
    tick(); idle();
    n_checks++;
    if (busy_vec !== 27'h0100000) begin n_fail++; $display("FAIL rst_mid_pre: got %h want 0100000", busy_vec); end
    rst = 1;
    tick();
    rst = 0; drive_a(13, 1, 0, 20, 1); #1;
    n_checks++;
    if (busy_vec !== 27'd0) begin n_fail++; $display("FAIL rst_mid_busy: got %h want 0", busy_vec); end
    n_checks++;
    if (issue_ready_a !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", issue_ready_a); end
    n_checks++;
    if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL rst_mid_stall: got %0d want 0", stall_cycles); end
    tick(); idle();
  endtask

  initial begin
    idle(); rst = 1;
    #1;
    test_reset();
    test_alu();
    test_load();
    test_dual();
    test_div();
    test_complete_same();
    test_r0_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
